// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared FSM state type and counter sizing helper for reset_seq.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        DEBOUNCE  = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    // Bits needed to hold values 0..limit; never less than one bit.
    function automatic int cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/reset_seq_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level.
// Clears to 0 on reset so a synchronised input reads as inactive.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/reset_seq.sv
// reset_seq: staged reset sequencer. Waits for the board reset button to be
// released and the clock generator to lock, debounces both, then releases
// rst_out one bit at a time, GAP_CYC cycles apart, bit 0 first.
// Optional lock watchdog is compiled in when RESET_SEQ_LOCK_WDT_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------
// HOLD      | all resets asserted for one cycle after any abort
// WAIT_LOCK | waiting for ext_rst_n released and dcm_locked
// DEBOUNCE  | both inputs must stay good for DEBOUNCE_CYC counted cycles
// RELEASE   | resets dropping one stage per GAP_CYC cycles
// RUN       | all resets released, seq_done high
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int N_OUT        = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int GAP_CYC      = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_rst_n,
    input  logic             dcm_locked,
    input  logic             sw_rst_req,
    output logic [N_OUT-1:0] rst_out,
    output logic             seq_done,
    output logic [2:0]       state_o,
    output logic             lock_timeout
);

    localparam int DEB_W = cnt_w(DEBOUNCE_CYC);
    localparam int GAP_W = cnt_w(GAP_CYC);
    localparam int STG_W = cnt_w(N_OUT);

    logic w_ext_s;
    logic w_lock_s;
    logic w_inputs_ok;
    logic w_abort;

    state_t             r_state, w_state_nxt;
    logic [DEB_W-1:0]   r_deb_cnt, w_deb_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
    logic [STG_W-1:0]   r_stage, w_stage_nxt;
    logic [STG_W-1:0]   w_stage_inc;
    logic [N_OUT-1:0]   r_rst_out, w_rst_nxt;
    logic               r_seq_done;

    sync_2ff u_sync_ext (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (ext_rst_n),
        .o_q     (w_ext_s)
    );

    sync_2ff u_sync_lock (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (dcm_locked),
        .o_q     (w_lock_s)
    );

    assign w_inputs_ok = w_ext_s & w_lock_s;
    assign w_abort     = ~w_inputs_ok | sw_rst_req;
    assign w_stage_inc = r_stage + 1'b1;

    // Next-state, counter and output-mask decode; abort always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_stage_nxt = r_stage;
        w_rst_nxt   = '1;
        case (r_state)
            HOLD: begin
                w_deb_nxt   = '0;
                w_gap_nxt   = '0;
                w_stage_nxt = '0;
                w_state_nxt = sw_rst_req ? HOLD : WAIT_LOCK;
            end
            WAIT_LOCK: begin
                w_deb_nxt = '0;
                if (sw_rst_req)       w_state_nxt = HOLD;
                else if (w_inputs_ok) w_state_nxt = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (sw_rst_req) begin
                    w_state_nxt = HOLD;
                    w_deb_nxt   = '0;
                end else if (!w_inputs_ok) begin
                    // A glitch restarts the wait rather than forcing HOLD;
                    // resets are still all asserted here so nothing is lost.
                    w_state_nxt = WAIT_LOCK;
                    w_deb_nxt   = '0;
                end else if (r_deb_cnt == DEB_W'(DEBOUNCE_CYC)) begin
                    w_state_nxt = RELEASE;
                    w_deb_nxt   = '0;
                    w_gap_nxt   = '0;
                    w_stage_nxt = STG_W'(1);
                end else begin
                    w_deb_nxt = r_deb_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (w_abort) begin
                    w_state_nxt = HOLD;
                    w_gap_nxt   = '0;
                    w_stage_nxt = '0;
                end else if (r_stage == STG_W'(N_OUT)) begin
                    w_state_nxt = RUN;
                end else if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    w_gap_nxt   = '0;
                    w_stage_nxt = w_stage_inc;
                    if (w_stage_inc == STG_W'(N_OUT)) w_state_nxt = RUN;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_state_nxt = HOLD;
                    w_stage_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = HOLD;
                w_deb_nxt   = '0;
                w_gap_nxt   = '0;
                w_stage_nxt = '0;
            end
        endcase
        if (w_state_nxt == RELEASE || w_state_nxt == RUN) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (k < int'(w_stage_nxt)) w_rst_nxt[k] = 1'b0;
            end
        end
    end

    // State, counters and registered (glitch-free) reset outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= HOLD;
            r_deb_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_stage    <= '0;
            r_rst_out  <= '1;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_deb_cnt  <= w_deb_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_stage    <= w_stage_nxt;
            r_rst_out  <= w_rst_nxt;
            r_seq_done <= (w_state_nxt == RUN);
        end
    end

    assign rst_out  = r_rst_out;
    assign seq_done = r_seq_done;
    assign state_o  = r_state;

`ifdef RESET_SEQ_LOCK_WDT_EN
    localparam int WDT_W = cnt_w(LOCK_TIMEOUT);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_lock_timeout;

    // Count unlocked WAIT_LOCK cycles; flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdt_cnt      <= '0;
            r_lock_timeout <= 1'b0;
        end else if (r_state != WAIT_LOCK) begin
            r_wdt_cnt <= '0;
        end else if (!w_lock_s && r_wdt_cnt != WDT_W'(LOCK_TIMEOUT)) begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
            if (r_wdt_cnt == WDT_W'(LOCK_TIMEOUT - 1)) r_lock_timeout <= 1'b1;
        end
    end

    assign lock_timeout = r_lock_timeout;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed bench for reset_seq (N_OUT=3, DEBOUNCE_CYC=4,
// GAP_CYC=2, LOCK_TIMEOUT=20). Edge numbers follow the sequencing examples:
// edge 0 is the first rising edge that samples the stimulus change.
module tb_reset_seq;

    localparam int N_OUT = 3;
`ifdef RESET_SEQ_LOCK_WDT_EN
    localparam logic WDT_ON = 1'b1;
`else
    localparam logic WDT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             ext_rst_n;
    logic             dcm_locked;
    logic             sw_rst_req;
    logic [N_OUT-1:0] rst_out;
    logic             seq_done;
    logic [2:0]       state_o;
    logic             lock_timeout;

    int n_chk = 0;
    int n_err = 0;
    int e     = 0;

    reset_seq #(
        .N_OUT        (N_OUT),
        .DEBOUNCE_CYC (4),
        .GAP_CYC      (2),
        .LOCK_TIMEOUT (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_rst_n    (ext_rst_n),
        .dcm_locked   (dcm_locked),
        .sw_rst_req   (sw_rst_req),
        .rst_out      (rst_out),
        .seq_done     (seq_done),
        .state_o      (state_o),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic go_to(input int n);
        while (e < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    // Reset with button held and clock locked, leaving the FSM in WAIT_LOCK.
    task automatic hard_reset();
        reset      = 1'b1;
        sw_rst_req = 1'b0;
        ext_rst_n  = 1'b0;
        dcm_locked = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

    // Release timing relative to edge 0: bit0 at 7, bit1 at 9, bit2 at 11.
    task automatic check_seq(input string tag);
        go_to(6);
        chk({tag, "_rst_e6"}, 32'(rst_out), 32'b111);
        chk({tag, "_st_e6"}, 32'(state_o), 32'd2);
        go_to(7);
        chk({tag, "_rst_e7"}, 32'(rst_out), 32'b110);
        chk({tag, "_st_e7"}, 32'(state_o), 32'd3);
        go_to(8);
        chk({tag, "_rst_e8"}, 32'(rst_out), 32'b110);
        go_to(9);
        chk({tag, "_rst_e9"}, 32'(rst_out), 32'b100);
        go_to(10);
        chk({tag, "_rst_e10"}, 32'(rst_out), 32'b100);
        chk({tag, "_done_e10"}, 32'(seq_done), 32'd0);
        go_to(11);
        chk({tag, "_rst_e11"}, 32'(rst_out), 32'b000);
        chk({tag, "_done_e11"}, 32'(seq_done), 32'd1);
        chk({tag, "_st_e11"}, 32'(state_o), 32'd4);
    endtask

    initial begin
        // Reset values.
        reset      = 1'b1;
        sw_rst_req = 1'b0;
        ext_rst_n  = 1'b0;
        dcm_locked = 1'b1;
        repeat (2) tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_rst_out", 32'(rst_out), 32'b111);
        chk("rst_done", 32'(seq_done), 32'd0);
        chk("rst_lockto", 32'(lock_timeout), 32'd0);

        // Basic sequence from button release.
        hard_reset();
        chk("wait_lock_state", 32'(state_o), 32'd1);
        ext_rst_n = 1'b1;
        e = -1;
        check_seq("seq");

        // Software reset in RUN, then identical re-sequence from the HOLD edge.
        tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("sw_rst_out", 32'(rst_out), 32'b111);
        chk("sw_state", 32'(state_o), 32'd0);
        chk("sw_done", 32'(seq_done), 32'd0);
        e = 0;
        check_seq("reseq");

        // One-cycle glitch on ext_rst_n during DEBOUNCE.
        hard_reset();
        ext_rst_n = 1'b1;
        e = -1;
        go_to(3);
        ext_rst_n = 1'b0;
        tick();
        ext_rst_n = 1'b1;
        go_to(6);
        chk("glitch_st_e6", 32'(state_o), 32'd1);
        for (int i = 7; i <= 11; i++) begin
            go_to(i);
            chk("glitch_no_early", 32'(rst_out), 32'b111);
        end
        go_to(12);
        chk("glitch_rst_e12", 32'(rst_out), 32'b110);
        go_to(14);
        chk("glitch_rst_e14", 32'(rst_out), 32'b100);
        go_to(16);
        chk("glitch_rst_e16", 32'(rst_out), 32'b000);
        chk("glitch_done_e16", 32'(seq_done), 32'd1);

        // Lock lost mid-RELEASE (sampled at edge 10).
        hard_reset();
        ext_rst_n = 1'b1;
        e = -1;
        go_to(9);
        dcm_locked = 1'b0;
        go_to(10);
        chk("unlock_rst_e10", 32'(rst_out), 32'b100);
        go_to(11);
        chk("unlock_rst_e11", 32'(rst_out), 32'b000);
        go_to(12);
        chk("unlock_rst_e12", 32'(rst_out), 32'b111);
        chk("unlock_done_e12", 32'(seq_done), 32'd0);
        chk("unlock_st_e12", 32'(state_o), 32'd0);
        go_to(13);
        chk("unlock_st_e13", 32'(state_o), 32'd1);

        // Synchronous reset at edge 9 overrides a running sequence.
        hard_reset();
        ext_rst_n = 1'b1;
        e = -1;
        go_to(8);
        chk("midrst_rst_e8", 32'(rst_out), 32'b110);
        reset = 1'b1;
        tick();
        chk("midrst_st_e9", 32'(state_o), 32'd0);
        chk("midrst_rst_e9", 32'(rst_out), 32'b111);
        chk("midrst_done_e9", 32'(seq_done), 32'd0);
        reset = 1'b0;

        // Lock watchdog: 20 unlocked WAIT_LOCK cycles starting at edge 1.
        reset      = 1'b1;
        ext_rst_n  = 1'b1;
        dcm_locked = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        e = 0;
        go_to(1);
        chk("wdt_st_e1", 32'(state_o), 32'd1);
        go_to(20);
        chk("wdt_flag_e20", 32'(lock_timeout), 32'd0);
        go_to(21);
        chk("wdt_flag_e21", 32'(lock_timeout), 32'(WDT_ON));
        dcm_locked = 1'b1;
        go_to(40);
        chk("wdt_run_e40", 32'(state_o), 32'd4);
        chk("wdt_sticky_e40", 32'(lock_timeout), 32'(WDT_ON));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
